// File: rtl/cplx_fxp_pkg.sv
// Shared formats for the fixed-point complex multiplier.
// Q5.27 operands, Q10.22 partial products and Q11.21 results, all 32-bit two's complement.
package cplx_fxp_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned ProdWidth = 2 * DataWidth;
  localparam int unsigned SumWidth  = DataWidth + 1;

  localparam int unsigned InFrac   = 27;
  localparam int unsigned ProdFrac = 22;
  localparam int unsigned ResFrac  = 21;

  // Q10.54 full product -> Q10.22 by dropping the low 32 bits (floor)
  localparam int unsigned ProdMsb = ProdWidth - 1;
  localparam int unsigned ProdLsb = (2 * InFrac) - ProdFrac;

  // Q11.22 sum -> Q11.21 by dropping one LSB (floor)
  localparam int unsigned SumMsb = SumWidth - 1;
  localparam int unsigned SumLsb = ProdFrac - ResFrac;

  // Sign-extend a word by one bit so that add/subtract cannot overflow.
  function automatic logic [SumWidth-1:0] sext_word(input logic [DataWidth-1:0] w);
    return {w[DataWidth-1], w};
  endfunction

endpackage

// File: rtl/fxp_mult_q527.sv
// Registered signed Q5.27 x Q5.27 multiplier, floored to Q10.22.
// The full product range fits Q10.54, so no overflow is possible.
module fxp_mult_q527
  import cplx_fxp_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  output logic [DataWidth-1:0] p_o
);

  logic [ProdWidth-1:0] a_ext;
  logic [ProdWidth-1:0] b_ext;
  logic [ProdWidth-1:0] prod;
  logic [DataWidth-1:0] p_d;
  logic [DataWidth-1:0] p_q;

  assign a_ext = {{(ProdWidth - DataWidth){a_i[DataWidth-1]}}, a_i};
  assign b_ext = {{(ProdWidth - DataWidth){b_i[DataWidth-1]}}, b_i};

  always_comb begin
    prod = $unsigned($signed(a_ext) * $signed(b_ext));
    // Keeping only the top half floors toward minus infinity.
    p_d  = prod[ProdMsb:ProdLsb];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/cplx_fxp_mult.sv
// Two-stage pipelined complex multiplier (a1 + j a2) x (b1 + j b2).
// Stage 1 registers the four partial products; stage 2 registers real and imaginary results.
module cplx_fxp_mult
  import cplx_fxp_pkg::*;
(
  input  logic                 clk_top,
  input  logic                 rst_top,
  input  logic [DataWidth-1:0] a1_top,
  input  logic [DataWidth-1:0] a2_top,
  input  logic [DataWidth-1:0] b1_top,
  input  logic [DataWidth-1:0] b2_top,
  output logic [DataWidth-1:0] a1b1_top,
  output logic [DataWidth-1:0] a2b2_top,
  output logic [DataWidth-1:0] a1b2_top,
  output logic [DataWidth-1:0] a2b1_top,
  output logic [DataWidth-1:0] ab_real_top,
  output logic [DataWidth-1:0] ab_imag_top
);

  logic [DataWidth-1:0] a1b1_q;
  logic [DataWidth-1:0] a2b2_q;
  logic [DataWidth-1:0] a1b2_q;
  logic [DataWidth-1:0] a2b1_q;

  logic [SumWidth-1:0]  real_sum;
  logic [SumWidth-1:0]  imag_sum;
  logic [DataWidth-1:0] real_d;
  logic [DataWidth-1:0] imag_d;
  logic [DataWidth-1:0] real_q;
  logic [DataWidth-1:0] imag_q;

  fxp_mult_q527 u_mult_a1b1 (
    .clk_i  (clk_top),
    .rst_ni (rst_top),
    .a_i    (a1_top),
    .b_i    (b1_top),
    .p_o    (a1b1_q)
  );

  fxp_mult_q527 u_mult_a2b2 (
    .clk_i  (clk_top),
    .rst_ni (rst_top),
    .a_i    (a2_top),
    .b_i    (b2_top),
    .p_o    (a2b2_q)
  );

  fxp_mult_q527 u_mult_a1b2 (
    .clk_i  (clk_top),
    .rst_ni (rst_top),
    .a_i    (a1_top),
    .b_i    (b2_top),
    .p_o    (a1b2_q)
  );

  fxp_mult_q527 u_mult_a2b1 (
    .clk_i  (clk_top),
    .rst_ni (rst_top),
    .a_i    (a2_top),
    .b_i    (b1_top),
    .p_o    (a2b1_q)
  );

  // Exact 33-bit add/subtract, then drop one LSB to land in Q11.21.
  always_comb begin
    real_sum = sext_word(a1b1_q) - sext_word(a2b2_q);
    imag_sum = sext_word(a1b2_q) + sext_word(a2b1_q);
    real_d   = real_sum[SumMsb:SumLsb];
    imag_d   = imag_sum[SumMsb:SumLsb];
  end

  always_ff @(posedge clk_top or negedge rst_top) begin
    if (!rst_top) begin
      real_q <= '0;
      imag_q <= '0;
    end else begin
      real_q <= real_d;
      imag_q <= imag_d;
    end
  end

  assign a1b1_top    = a1b1_q;
  assign a2b2_top    = a2b2_q;
  assign a1b2_top    = a1b2_q;
  assign a2b1_top    = a2b1_q;
  assign ab_real_top = real_q;
  assign ab_imag_top = imag_q;

endmodule

// File: tb/tb_cplx_fxp_mult.sv
// Scoreboard bench for cplx_fxp_mult: products checked one edge after drive, results two.
module tb_cplx_fxp_mult;

  typedef struct {
    logic [31:0] a1b1;
    logic [31:0] a2b2;
    logic [31:0] a1b2;
    logic [31:0] a2b1;
    logic [31:0] re;
    logic [31:0] im;
  } exp_t;

  logic        clk_top = 1'b0;
  logic        rst_top;
  logic [31:0] a1_top, a2_top, b1_top, b2_top;
  logic [31:0] a1b1_top, a2b2_top, a1b2_top, a2b1_top, ab_real_top, ab_imag_top;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t prod_q[$];
  exp_t res_q[$];

  cplx_fxp_mult dut (
    .clk_top     (clk_top),
    .rst_top     (rst_top),
    .a1_top      (a1_top),
    .a2_top      (a2_top),
    .b1_top      (b1_top),
    .b2_top      (b2_top),
    .a1b1_top    (a1b1_top),
    .a2b2_top    (a2b2_top),
    .a1b2_top    (a1b2_top),
    .a2b1_top    (a2b1_top),
    .ab_real_top (ab_real_top),
    .ab_imag_top (ab_imag_top)
  );

  always #5 clk_top = ~clk_top;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: exact 64-bit products floored to Q10.22, exact sums floored to Q11.21.
  function automatic exp_t model(input logic [31:0] a1, input logic [31:0] a2,
                                 input logic [31:0] b1, input logic [31:0] b2);
    exp_t   m;
    longint p, s;
    p = longint'($signed(a1)) * longint'($signed(b1)); m.a1b1 = p[63:32];
    p = longint'($signed(a2)) * longint'($signed(b2)); m.a2b2 = p[63:32];
    p = longint'($signed(a1)) * longint'($signed(b2)); m.a1b2 = p[63:32];
    p = longint'($signed(a2)) * longint'($signed(b1)); m.a2b1 = p[63:32];
    s = longint'($signed(m.a1b1)) - longint'($signed(m.a2b2)); m.re = s[32:1];
    s = longint'($signed(m.a1b2)) + longint'($signed(m.a2b1)); m.im = s[32:1];
    return m;
  endfunction

  task automatic drive(input logic [31:0] a1, input logic [31:0] a2,
                       input logic [31:0] b1, input logic [31:0] b2, input exp_t e);
    @(negedge clk_top);
    a1_top = a1; a2_top = a2; b1_top = b1; b2_top = b2;
    prod_q.push_back(e);
  endtask

  task automatic drive_rand();
    logic [31:0] a1, a2, b1, b2;
    a1 = $urandom; a2 = $urandom; b1 = $urandom; b2 = $urandom;
    drive(a1, a2, b1, b2, model(a1, a2, b1, b2));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_a1b1"}, a1b1_top, 32'h0);
    check_eq({tag, "_a2b2"}, a2b2_top, 32'h0);
    check_eq({tag, "_a1b2"}, a1b2_top, 32'h0);
    check_eq({tag, "_a2b1"}, a2b1_top, 32'h0);
    check_eq({tag, "_real"}, ab_real_top, 32'h0);
    check_eq({tag, "_imag"}, ab_imag_top, 32'h0);
  endtask

  // Asserted off-edge; released on a negedge with a zero result expected at the first edge.
  task automatic pulse_reset(input string tag);
    exp_t z;
    z = '{default: 32'h0};
    @(negedge clk_top);
    #1 rst_top = 1'b0;
    prod_q.delete();
    res_q.delete();
    #1 check_all_zero({tag, "_async"});
    repeat (2) @(posedge clk_top);
    #1 check_all_zero({tag, "_held"});
    @(negedge clk_top);
    rst_top = 1'b1;
    res_q.push_back(z);
  endtask

  // Monitor: sample just after each rising edge.
  always begin
    exp_t e;
    @(posedge clk_top);
    #1;
    if (rst_top) begin
      if (res_q.size() > 0) begin
        e = res_q.pop_front();
        check_eq("real", ab_real_top, e.re);
        check_eq("imag", ab_imag_top, e.im);
      end
      if (prod_q.size() > 0) begin
        e = prod_q.pop_front();
        check_eq("a1b1", a1b1_top, e.a1b1);
        check_eq("a2b2", a2b2_top, e.a2b2);
        check_eq("a1b2", a1b2_top, e.a1b2);
        check_eq("a2b1", a2b1_top, e.a2b1);
        res_q.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    z = '{default: 32'h0};
    rst_top = 1'b0;
    a1_top = 32'h12345678; a2_top = 32'h9abcdef0;
    b1_top = 32'h0fedcba9; b2_top = 32'h87654321;
    #3 check_all_zero("rst_init");
    repeat (3) @(posedge clk_top);
    #1 check_all_zero("rst_held");
    @(negedge clk_top);
    rst_top = 1'b1;
    res_q.push_back(z);

    // Directed cases back to back: a1b1, a2b2, a1b2, a2b1, real, imag.
    drive(32'h08000000, 32'h0, 32'h08000000, 32'h0,
          '{32'h00400000, 32'h0, 32'h0, 32'h0, 32'h00200000, 32'h0});
    drive(32'h10000000, 32'h18000000, 32'h0C000000, 32'hF8000000,
          '{32'h00C00000, 32'hFF400000, 32'hFF800000, 32'h01200000, 32'h00C00000, 32'h00500000});
    drive(32'h80000000, 32'h80000000, 32'h80000000, 32'h7FFFFFFF,
          '{32'h40000000, 32'hC0000000, 32'hC0000000, 32'h40000000, 32'h40000000, 32'h0});
    drive(32'hFFFFFFFF, 32'h0, 32'h00000001, 32'h0,
          '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0});

    // Back-to-back random sets, then reset in the middle of the stream.
    for (int i = 0; i < 24; i++) drive_rand();
    pulse_reset("rst_mid");
    for (int i = 0; i < 8; i++) drive_rand();
    repeat (4) @(posedge clk_top);
    #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
